store_buffer: RTL and testbench

- Write-side counterpart of load_buffer: holds address-resolved stores from the ACU, retires them in program order on ROB commit, and drains committed stores to MEM as single write requests.
- Drives pending_stores to the ROB/load_buffer path so loads are held while any store is buffered.
- Sits between ACU (allocate), ROB (commit/squash) and MEM (write port shared with load_buffer reads).

---
 rtl/store_buffer_pkg.sv | 35 +++
 rtl/sb_fwd_match.sv | 35 +++
 rtl/store_buffer.sv | 171 +++++++++++++++++
 tb/tb_store_buffer.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/store_buffer_pkg.sv
// Shared types for the store buffer: ACU packet, buffer entry, head view and MEM size codes.
package store_buffer_pkg;

  localparam int unsigned XLEN        = 32;
  localparam int unsigned ROB_TAG_LEN = 5;

  localparam logic [1:0] MEM_SIZE_BYTE = 2'b00;
  localparam logic [1:0] MEM_SIZE_HALF = 2'b01;
  localparam logic [1:0] MEM_SIZE_WORD = 2'b10;

  typedef struct packed {
    logic                   valid;
    logic [XLEN-1:0]        address;
    logic [XLEN-1:0]        data;
    logic [1:0]             mem_size;
    logic [ROB_TAG_LEN-1:0] rob_tag;
  } SB_PACKET;

  typedef struct packed {
    logic                   valid;
    logic                   committed;
    logic [XLEN-1:0]        address;
    logic [XLEN-1:0]        data;
    logic [1:0]             mem_size;
    logic [ROB_TAG_LEN-1:0] rob_tag;
  } SB_ENTRY;

  typedef struct packed {
    logic [XLEN-1:0]        address;
    logic [XLEN-1:0]        data;
    logic [1:0]             mem_size;
    logic [ROB_TAG_LEN-1:0] rob_tag;
  } SB_HEAD;

endpackage

// File: rtl/sb_fwd_match.sv
// Youngest-first address match over the store buffer; only built with STORE_BUFFER_FORWARD_EN.
`ifdef STORE_BUFFER_FORWARD_EN
module sb_fwd_match
  import store_buffer_pkg::*;
#(
  parameter int unsigned SB_DEPTH   = 4,
  parameter int unsigned SB_IDX_LEN = $clog2(SB_DEPTH)
) (
  input  logic [SB_DEPTH-1:0]   cand_i,
  input  logic [XLEN-1:0]       address_i [SB_DEPTH],
  input  logic [XLEN-1:0]       data_i    [SB_DEPTH],
  input  logic [SB_IDX_LEN-1:0] head_ptr_i,
  input  logic [XLEN-1:0]       fwd_address_i,
  output logic                  fwd_hit_o,
  output logic [XLEN-1:0]       fwd_data_o
);

  logic [SB_IDX_LEN-1:0] idx;

  // Walk oldest to youngest so the last match seen (the youngest) wins.
  always_comb begin
    fwd_hit_o  = 1'b0;
    fwd_data_o = '0;
    idx        = head_ptr_i;
    for (int unsigned k = 0; k < SB_DEPTH; k++) begin
      idx = head_ptr_i + k[SB_IDX_LEN-1:0];
      if (cand_i[idx] && (address_i[idx] == fwd_address_i)) begin
        fwd_hit_o  = 1'b1;
        fwd_data_o = data_i[idx];
      end
    end
  end

endmodule
`endif

// File: rtl/store_buffer.sv
// In-order store buffer: allocate from ACU, commit from ROB, drain committed stores to MEM.
// Optional store-to-load forwarding is enabled by defining STORE_BUFFER_FORWARD_EN.
module store_buffer
  import store_buffer_pkg::*;
#(
  parameter int unsigned SB_DEPTH   = 4,
  parameter int unsigned SB_IDX_LEN = $clog2(SB_DEPTH)
) (
  input  logic                   clock,
  input  logic                   reset,
  input  SB_PACKET               sb_packet_in,
  input  logic                   alloc_enable,
  input  logic                   commit_enable,
  input  logic                   squash,
  input  logic                   mem_busy,
`ifdef STORE_BUFFER_FORWARD_EN
  input  logic [XLEN-1:0]        fwd_address,
  output logic                   fwd_hit,
  output logic [XLEN-1:0]        fwd_data,
`endif
  output logic                   full,
  output logic                   pending_stores,
  output logic                   write_mem,
  output logic [XLEN-1:0]        store_address,
  output logic [XLEN-1:0]        store_data,
  output logic [1:0]             store_size,
  output logic [ROB_TAG_LEN-1:0] store_rob_tag
);

  localparam logic [SB_IDX_LEN:0]   CntOne  = (SB_IDX_LEN+1)'(1);
  localparam logic [SB_IDX_LEN:0]   CntFull = (SB_IDX_LEN+1)'(SB_DEPTH);
  localparam logic [SB_IDX_LEN-1:0] PtrOne  = SB_IDX_LEN'(1);

  SB_ENTRY               entries_q [SB_DEPTH];
  SB_ENTRY               entries_d [SB_DEPTH];
  logic [SB_IDX_LEN-1:0] head_ptr_q, head_ptr_d, tail_ptr_q, tail_ptr_d, commit_idx;
  logic [SB_IDX_LEN:0]   count_q, count_d, commit_count_q, commit_count_d;
  SB_HEAD                last_q, last_d, head_view;
  logic                  alloc_req, alloc_ok, commit_ok, pop;

  assign full           = (count_q == CntFull);
  assign pending_stores = (count_q != '0);
  assign write_mem      = entries_q[head_ptr_q].valid && entries_q[head_ptr_q].committed &&
                          !mem_busy;

  assign alloc_req  = alloc_enable && sb_packet_in.valid && !squash;
  assign alloc_ok   = alloc_req && !full;
  assign commit_ok  = commit_enable && (commit_count_q < count_q);
  assign pop        = write_mem;
  assign commit_idx = head_ptr_q + commit_count_q[SB_IDX_LEN-1:0];

  // Empty buffer keeps presenting the last popped store.
  always_comb begin
    if (count_q != '0) begin
      head_view = '{address:  entries_q[head_ptr_q].address,
                    data:     entries_q[head_ptr_q].data,
                    mem_size: entries_q[head_ptr_q].mem_size,
                    rob_tag:  entries_q[head_ptr_q].rob_tag};
    end else begin
      head_view = last_q;
    end
  end

  assign store_address = head_view.address;
  assign store_data    = head_view.data;
  assign store_size    = head_view.mem_size;
  assign store_rob_tag = head_view.rob_tag;

  always_comb begin
    entries_d      = entries_q;
    head_ptr_d     = head_ptr_q;
    tail_ptr_d     = tail_ptr_q;
    count_d        = count_q;
    commit_count_d = commit_count_q;
    last_d         = last_q;

    if (commit_ok) begin
      entries_d[commit_idx].committed = 1'b1;
      commit_count_d                  = commit_count_d + CntOne;
    end

    if (pop) begin
      entries_d[head_ptr_q].valid     = 1'b0;
      entries_d[head_ptr_q].committed = 1'b0;
      head_ptr_d                      = head_ptr_q + PtrOne;
      count_d                         = count_d - CntOne;
      commit_count_d                  = commit_count_d - CntOne;
      last_d = '{address:  entries_q[head_ptr_q].address,
                 data:     entries_q[head_ptr_q].data,
                 mem_size: entries_q[head_ptr_q].mem_size,
                 rob_tag:  entries_q[head_ptr_q].rob_tag};
    end

    if (alloc_ok) begin
      entries_d[tail_ptr_q] = '{valid:     1'b1,
                                committed: 1'b0,
                                address:   sb_packet_in.address,
                                data:      sb_packet_in.data,
                                mem_size:  sb_packet_in.mem_size,
                                rob_tag:   sb_packet_in.rob_tag};
      tail_ptr_d            = tail_ptr_q + PtrOne;
      count_d               = count_d + CntOne;
    end

    // Squash sees this edge's commit and pop; only committed stores survive.
    if (squash) begin
      for (int unsigned i = 0; i < SB_DEPTH; i++) begin
        if (!entries_d[i[SB_IDX_LEN-1:0]].committed) begin
          entries_d[i[SB_IDX_LEN-1:0]].valid = 1'b0;
        end
      end
      tail_ptr_d = head_ptr_d + commit_count_d[SB_IDX_LEN-1:0];
      count_d    = commit_count_d;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      entries_q      <= '{default: '0};
      head_ptr_q     <= '0;
      tail_ptr_q     <= '0;
      count_q        <= '0;
      commit_count_q <= '0;
      last_q         <= '0;
    end else begin
      entries_q      <= entries_d;
      head_ptr_q     <= head_ptr_d;
      tail_ptr_q     <= tail_ptr_d;
      count_q        <= count_d;
      commit_count_q <= commit_count_d;
      last_q         <= last_d;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      assert (!(alloc_req && full))
        else $warning("store_buffer: allocation while full dropped");
      assert (!(commit_enable && !commit_ok))
        else $warning("store_buffer: commit with no uncommitted store ignored");
    end
  end

`ifdef STORE_BUFFER_FORWARD_EN
  logic [SB_DEPTH-1:0] fwd_cand;
  logic [XLEN-1:0]     fwd_addr_arr [SB_DEPTH];
  logic [XLEN-1:0]     fwd_data_arr [SB_DEPTH];

  always_comb begin
    for (int unsigned i = 0; i < SB_DEPTH; i++) begin
      fwd_cand[i]     = entries_q[i].valid && (entries_q[i].mem_size == MEM_SIZE_WORD);
      fwd_addr_arr[i] = entries_q[i].address;
      fwd_data_arr[i] = entries_q[i].data;
    end
  end

  sb_fwd_match #(
    .SB_DEPTH   (SB_DEPTH),
    .SB_IDX_LEN (SB_IDX_LEN)
  ) u_fwd_match (
    .cand_i        (fwd_cand),
    .address_i     (fwd_addr_arr),
    .data_i        (fwd_data_arr),
    .head_ptr_i    (head_ptr_q),
    .fwd_address_i (fwd_address),
    .fwd_hit_o     (fwd_hit),
    .fwd_data_o    (fwd_data)
  );
`endif

endmodule

// File: tb/tb_store_buffer.sv
// Directed self-checking bench for store_buffer (depth 4).
module tb_store_buffer;
  import store_buffer_pkg::*;

  logic                   clock = 1'b0;
  logic                   reset;
  SB_PACKET               sb_packet_in;
  logic                   alloc_enable, commit_enable, squash, mem_busy;
  logic                   full, pending_stores, write_mem;
  logic [XLEN-1:0]        store_address, store_data;
  logic [1:0]             store_size;
  logic [ROB_TAG_LEN-1:0] store_rob_tag;
`ifdef STORE_BUFFER_FORWARD_EN
  logic [XLEN-1:0]        fwd_address, fwd_data;
  logic                   fwd_hit;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clock = ~clock;

  store_buffer #(
    .SB_DEPTH (4)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .sb_packet_in   (sb_packet_in),
    .alloc_enable   (alloc_enable),
    .commit_enable  (commit_enable),
    .squash         (squash),
    .mem_busy       (mem_busy),
`ifdef STORE_BUFFER_FORWARD_EN
    .fwd_address    (fwd_address),
    .fwd_hit        (fwd_hit),
    .fwd_data       (fwd_data),
`endif
    .full           (full),
    .pending_stores (pending_stores),
    .write_mem      (write_mem),
    .store_address  (store_address),
    .store_data     (store_data),
    .store_size     (store_size),
    .store_rob_tag  (store_rob_tag)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic put(input logic [31:0] addr, input logic [31:0] data, input logic [1:0] size,
                     input logic [4:0] tag);
    sb_packet_in = '{valid: 1'b1, address: addr, data: data, mem_size: size, rob_tag: tag};
    alloc_enable = 1'b1;
  endtask

  initial begin
    reset         = 1'b0;
    sb_packet_in  = '0;
    alloc_enable  = 1'b0;
    commit_enable = 1'b0;
    squash        = 1'b0;
    mem_busy      = 1'b0;
`ifdef STORE_BUFFER_FORWARD_EN
    fwd_address   = '0;
`endif
    step();
    step();
    check("rst_full", full, 0);
    check("rst_pending", pending_stores, 0);
    check("rst_write_mem", write_mem, 0);
    check("rst_address", store_address, 0);
    check("rst_data", store_data, 0);
    check("rst_size", store_size, 0);
    check("rst_tag", store_rob_tag, 0);
    reset = 1'b1;
    step();

    // Single store: held while uncommitted and while MEM is busy.
    put(32'h8, 32'hAA, 2'b10, 5'd2);
    step();
    alloc_enable = 1'b0;
    check("t1_pending", pending_stores, 1);
    check("t1_address", store_address, 32'h8);
    check("t1_data", store_data, 32'hAA);
    check("t1_size", store_size, 2'b10);
    check("t1_tag", store_rob_tag, 5'd2);
    check("t1_wm_uncommitted", write_mem, 0);
    mem_busy      = 1'b1;
    commit_enable = 1'b1;
    step();
    commit_enable = 1'b0;
    check("t1_wm_busy0", write_mem, 0);
    step();
    check("t1_wm_busy1", write_mem, 0);
    mem_busy = 1'b0;
    #1;
    check("t1_wm_drain", write_mem, 1);
    check("t1_drain_addr", store_address, 32'h8);
    check("t1_drain_data", store_data, 32'hAA);
    step();
    check("t1_wm_single", write_mem, 0);
    check("t1_empty", pending_stores, 0);
    check("t1_hold_addr", store_address, 32'h8);

    // Fill to full, overflow dropped, then commit+pop on the same edges.
    for (int i = 1; i <= 4; i++) begin
      put(32'(4 * i), 32'(32'h100 + 4 * i), 2'b10, 5'(i));
      step();
    end
    check("t2_full", full, 1);
    put(32'h14, 32'h114, 2'b10, 5'd9);
    step();
    alloc_enable = 1'b0;
    check("t2_full_hold", full, 1);
    check("t2_head", store_address, 32'h4);
    commit_enable = 1'b1;
    step();
    check("t2_wm0", write_mem, 1);
    check("t2_addr0", store_address, 32'h4);
    step();
    check("t2_notfull", full, 0);
    check("t2_wm1", write_mem, 1);
    check("t2_addr1", store_address, 32'h8);
    step();
    check("t2_wm2", write_mem, 1);
    check("t2_addr2", store_address, 32'hC);
    step();
    commit_enable = 1'b0;
    check("t2_wm3", write_mem, 1);
    check("t2_addr3", store_address, 32'h10);
    check("t2_data3", store_data, 32'h110);
    step();
    check("t2_empty", pending_stores, 0);
    check("t2_wm_end", write_mem, 0);
    check("t2_hold_addr", store_address, 32'h10);

    // Squash keeps only the committed store; refill wraps the tail.
    put(32'h40, 32'h1, 2'b10, 5'd4);
    step();
    put(32'h44, 32'h2, 2'b10, 5'd5);
    step();
    put(32'h48, 32'h3, 2'b10, 5'd6);
    step();
    alloc_enable  = 1'b0;
    mem_busy      = 1'b1;
    commit_enable = 1'b1;
    step();
    commit_enable = 1'b0;
    squash        = 1'b1;
    step();
    squash = 1'b0;
    check("t3_pending", pending_stores, 1);
    check("t3_wm_busy", write_mem, 0);
    check("t3_head", store_address, 32'h40);
    check("t3_notfull", full, 0);
    put(32'h50, 32'h5, 2'b00, 5'd7);
    step();
    put(32'h54, 32'h6, 2'b10, 5'd8);
    step();
    put(32'h58, 32'h7, 2'b10, 5'd9);
    step();
    alloc_enable = 1'b0;
    check("t3_full", full, 1);
    check("t3_head_size", store_size, 2'b10);
    mem_busy = 1'b0;
    #1;
    check("t3_wm0", write_mem, 1);
    check("t3_addr0", store_address, 32'h40);
    commit_enable = 1'b1;
    step();
    check("t3_wm1", write_mem, 1);
    check("t3_addr1", store_address, 32'h50);
    check("t3_size1", store_size, 2'b00);
    check("t3_notfull2", full, 0);
    step();
    check("t3_addr2", store_address, 32'h54);
    step();
    commit_enable = 1'b0;
    check("t3_wm3", write_mem, 1);
    check("t3_addr3", store_address, 32'h58);
    step();
    check("t3_empty", pending_stores, 0);

    // Allocate on the pop edge while full: pop wins, allocation dropped.
    for (int i = 0; i < 4; i++) begin
      put(32'(32'h60 + 4 * i), 32'(32'h200 + i), 2'b10, 5'(10 + i));
      step();
    end
    alloc_enable = 1'b0;
    check("t4_full", full, 1);
    commit_enable = 1'b1;
    step();
    commit_enable = 1'b0;
    check("t4_wm", write_mem, 1);
    check("t4_addr", store_address, 32'h60);
    put(32'h70, 32'h300, 2'b10, 5'd20);
    step();
    alloc_enable = 1'b0;
    check("t4_notfull", full, 0);
    check("t4_wm_next", write_mem, 0);
    check("t4_head", store_address, 32'h64);
    commit_enable = 1'b1;
    step();
    check("t4_addr1", store_address, 32'h64);
    check("t4_wm1", write_mem, 1);
    step();
    check("t4_addr2", store_address, 32'h68);
    step();
    commit_enable = 1'b0;
    check("t4_addr3", store_address, 32'h6C);
    check("t4_data3", store_data, 32'h203);
    step();
    check("t4_empty", pending_stores, 0);
    check("t4_wm_end", write_mem, 0);

`ifdef STORE_BUFFER_FORWARD_EN
    put(32'h10, 32'h1, 2'b10, 5'd1);
    step();
    put(32'h10, 32'h2, 2'b10, 5'd2);
    step();
    alloc_enable = 1'b0;
    fwd_address  = 32'h10;
    #1;
    check("fwd_hit", fwd_hit, 1);
    check("fwd_data", fwd_data, 32'h2);
    fwd_address = 32'h14;
    #1;
    check("fwd_miss", fwd_hit, 0);
    check("fwd_miss_data", fwd_data, 0);
    squash = 1'b1;
    step();
    squash = 1'b0;
    check("fwd_squash_empty", pending_stores, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
